// File: rtl/layer_sequencer_if.sv
// Jump-request / block-chain bundle for layer_sequencer.
// master: the sequencer; slave: input logic and block chain.
interface layer_sequencer_if;
    logic       jump_left;
    logic       jump_right;
    logic       shift_start;
    logic [6:0] layer_map;
    logic [6:0] block_type;
    logic [2:0] player_col;
    logic       busy;
    logic       game_over;

    modport master (
        input  jump_left,
        input  jump_right,
        output shift_start,
        output layer_map,
        output block_type,
        output player_col,
        output busy,
        output game_over
    );

    modport slave (
        output jump_left,
        output jump_right,
        input  shift_start,
        input  layer_map,
        input  block_type,
        input  player_col,
        input  busy,
        input  game_over
    );
endinterface

// File: rtl/layer_sequencer.sv
// Platform-layer sequencer: landing check, LFSR layer generation, shift pacing.
// Optional macro LAYER_SEQ_QUEUE_EN adds a one-entry jump buffer during slides.
module layer_sequencer #(
    parameter int          NUM_LAYERS = 5,
    parameter int          SHIFT_MS   = 150,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              one_ms_tick,
    input  logic              game_en,
    layer_sequencer_if.master seq
);
    localparam logic [6:0] ODD_MASK  = 7'b1010101;
    localparam logic [6:0] EVEN_MASK = 7'b0101010;
    localparam logic [6:0] HOME_ROW  = 7'b0001000;
    localparam logic [2:0] HOME_COL  = 3'd3;
    localparam int         CW        = $clog2(SHIFT_MS + 1);
    localparam logic [CW-1:0] LAST   = CW'(SHIFT_MS - 1);
    // par_q=1: next layer uses the odd mask (opposite of the top row).
    localparam bit PAR_INIT = ((NUM_LAYERS - 1) % 2) == 0;

    typedef enum logic [1:0] {IDLE, GEN, SHIFT, OVER} state_t;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [6:0]    hist_q [NUM_LAYERS];
    logic [2:0]    col_q;
    logic [2:0]    tgt_q;
    logic          par_q;
    logic [CW-1:0] cnt_q;
    logic          shift_q;
    logic [6:0]    map_q;
    logic [6:0]    type_q;
    logic          busy_q;
    logic          over_q;

    function automatic logic [6:0] init_layer(input int k);
        if (k == 0) return HOME_ROW;
        return (k % 2 == 1) ? ODD_MASK : EVEN_MASK;
    endfunction

    logic       req_one;
    logic       req_v;
    logic       go_left;
    logic [2:0] tgt_d;
    logic       in_range;
    logic       req_ok;

    assign req_one = seq.jump_left ^ seq.jump_right;

`ifdef LAYER_SEQ_QUEUE_EN
    logic pend_q;
    logic pend_left_q;
    assign req_v   = pend_q | req_one;
    assign go_left = pend_q ? pend_left_q : seq.jump_left;
`else
    assign req_v   = req_one;
    assign go_left = seq.jump_left;
`endif

    assign tgt_d    = go_left ? col_q - 3'd1 : col_q + 3'd1;
    assign in_range = go_left ? (col_q != 3'd0) : (col_q != 3'd6);
    assign req_ok   = req_v & in_range;

    logic [6:0] mask;
    logic [6:0] top;
    logic [6:0] raw0;
    logic [6:0] reach;
    logic [6:0] low_bit;
    logic [6:0] raw;

    assign mask    = par_q ? ODD_MASK : EVEN_MASK;
    assign top     = hist_q[NUM_LAYERS-1];
    assign raw0    = lfsr_q[6:0] & mask;
    assign reach   = mask & ((top << 1) | (top >> 1));
    assign low_bit = reach & (~reach + 7'd1);
    assign raw     = ((raw0 & reach) == 7'd0) ? (raw0 | low_bit) : raw0;

    // Free-running LFSR, cleared only by the hardware reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Control FSM with shadow history and registered chain outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_LAYERS; k++) hist_q[k] <= init_layer(k);
            col_q   <= HOME_COL;
            tgt_q   <= HOME_COL;
            par_q   <= PAR_INIT;
            cnt_q   <= '0;
            shift_q <= 1'b0;
            map_q   <= 7'd0;
            type_q  <= 7'd0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
`ifdef LAYER_SEQ_QUEUE_EN
            pend_q      <= 1'b0;
            pend_left_q <= 1'b0;
`endif
        end else if (!game_en) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_LAYERS; k++) hist_q[k] <= init_layer(k);
            col_q   <= HOME_COL;
            tgt_q   <= HOME_COL;
            par_q   <= PAR_INIT;
            cnt_q   <= '0;
            shift_q <= 1'b0;
            map_q   <= 7'd0;
            type_q  <= 7'd0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
`ifdef LAYER_SEQ_QUEUE_EN
            pend_q      <= 1'b0;
            pend_left_q <= 1'b0;
`endif
        end else begin
            shift_q <= 1'b0;
`ifdef LAYER_SEQ_QUEUE_EN
            if (busy_q && req_one && !pend_q) begin
                pend_q      <= 1'b1;
                pend_left_q <= seq.jump_left;
            end
`endif
            unique case (state_q)
                IDLE: begin
`ifdef LAYER_SEQ_QUEUE_EN
                    pend_q <= 1'b0;
`endif
                    if (req_ok) begin
                        tgt_q <= tgt_d;
                        if (hist_q[1][tgt_d]) begin
                            state_q <= GEN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= OVER;
                            over_q  <= 1'b1;
                        end
                    end
                end
                GEN: begin
                    map_q  <= raw;
                    type_q <= lfsr_q[14:8] & raw;
                    for (int k = 0; k < NUM_LAYERS - 1; k++) hist_q[k] <= hist_q[k+1];
                    hist_q[NUM_LAYERS-1] <= raw;
                    col_q   <= tgt_q;
                    par_q   <= ~par_q;
                    shift_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (one_ms_tick) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                OVER: begin
                    over_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign seq.shift_start = shift_q;
    assign seq.layer_map   = map_q;
    assign seq.block_type  = type_q;
    assign seq.player_col  = col_q;
    assign seq.busy        = busy_q;
    assign seq.game_over   = over_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (NUM_LAYERS=4, SHIFT_MS=3).
// Vector table for single-jump cases plus hand sequences for multi-cycle cases.
module tb_layer_sequencer;
    localparam logic [6:0] ODD  = 7'b1010101;
    localparam logic [6:0] EVEN = 7'b0101010;
    localparam logic [6:0] HOME = 7'b0001000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic game_en = 1'b0;

    layer_sequencer_if bus ();

    layer_sequencer #(
        .NUM_LAYERS(4),
        .SHIFT_MS  (3),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .one_ms_tick(tick),
        .game_en    (game_en),
        .seq        (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference LFSR, stepped on the same edges as the design.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [6:0] genl(input logic [15:0] l, input logic [6:0] m,
                                       input logic [6:0] t);
        logic [6:0] rw;
        logic [6:0] r;
        rw = l[6:0] & m;
        r  = m & ({t[5:0], 1'b0} | {1'b0, t[6:1]});
        if ((rw & r) == 7'd0) begin
            for (int i = 6; i >= 0; i--) if (r[i]) rw = 7'd1 << i;
            rw = rw | (l[6:0] & m);
        end
        return rw;
    endfunction

    logic [6:0] eh [4];
    logic       epar;
    logic [2:0] ecol;

    task automatic model_init();
        eh[0] = HOME; eh[1] = ODD; eh[2] = EVEN; eh[3] = ODD;
        epar = 1'b0;
        ecol = 3'd3;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reinit();
        game_en = 1'b0;
        cyc();
        game_en = 1'b1;
        model_init();
    endtask

    // Full safe jump with generated-layer prediction and 3-tick slide.
    task automatic move(input bit left);
        logic [15:0] l1;
        logic [6:0]  rw;
        logic [2:0]  tc;
        l1 = lstep(m_lfsr);
        rw = genl(l1, epar ? ODD : EVEN, eh[3]);
        tc = left ? ecol - 3'd1 : ecol + 3'd1;
        bus.jump_left = left;
        bus.jump_right = !left;
        cyc();
        bus.jump_left = 1'b0;
        bus.jump_right = 1'b0;
        chk("mv_busy_gen", bus.busy, 1);
        chk("mv_over", bus.game_over, 0);
        cyc();
        chk("mv_ss", bus.shift_start, 1);
        chk("mv_map", bus.layer_map, rw);
        chk("mv_type", bus.block_type, l1[14:8] & rw);
        chk("mv_col", bus.player_col, tc);
        tick = 1'b1;
        cyc();
        chk("mv_ss_drop", bus.shift_start, 0);
        cyc();
        chk("mv_busy_2ticks", bus.busy, 1);
        cyc();
        tick = 1'b0;
        chk("mv_busy_end", bus.busy, 0);
        eh[0] = eh[1]; eh[1] = eh[2]; eh[2] = eh[3]; eh[3] = rw;
        epar = ~epar;
        ecol = tc;
    endtask

    typedef struct {
        logic       jl;
        logic       jr;
        logic       en;
        logic       e_busy;
        logic       e_over;
        logic       e_ss;
        logic [2:0] e_col;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] l1;
        logic [6:0]  rw;
        int          w;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3};

        bus.jump_left = 1'b0;
        bus.jump_right = 1'b0;
        model_init();

        // Reset values while rst is held low.
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ss", bus.shift_start, 0);
        chk("rst_map", bus.layer_map, 0);
        chk("rst_type", bus.block_type, 0);
        chk("rst_col", bus.player_col, 3);
        chk("rst_over", bus.game_over, 0);
        rst = 1'b1;
        cyc();
        game_en = 1'b1;

        // Single jumps from the home position.
        for (int i = 0; i < 5; i++) begin
            reinit();
            bus.jump_left = vecs[i].jl;
            bus.jump_right = vecs[i].jr;
            game_en = vecs[i].en;
            cyc();
            bus.jump_left = 1'b0;
            bus.jump_right = 1'b0;
            game_en = 1'b1;
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_over", i), bus.game_over, vecs[i].e_over);
            cyc();
            chk($sformatf("vec%0d_ss", i), bus.shift_start, vecs[i].e_ss);
            chk($sformatf("vec%0d_col", i), bus.player_col, vecs[i].e_col);
        end

        // Empty random layer falls back to the lowest reachable column.
        reinit();
        w = 0;
        while (((lstep(m_lfsr) & 16'h002A) != 16'h0) && w < 256) begin
            cyc();
            w++;
        end
        chk("wait_fallback", w < 256, 1);
        l1 = lstep(m_lfsr);
        bus.jump_right = 1'b1;
        cyc();
        bus.jump_right = 1'b0;
        chk("fb_busy", bus.busy, 1);
        cyc();
        chk("fb_ss", bus.shift_start, 1);
        chk("fb_map", bus.layer_map, 7'b0000010);
        chk("fb_type", bus.block_type, l1[14:8] & 7'b0000010);
        chk("fb_col", bus.player_col, 4);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        bus.jump_left = 1'b1;
        cyc();
        bus.jump_left = 1'b0;
        chk("fb_busy_1tick", bus.busy, 1);
        tick = 1'b1;
        cyc();
        chk("fb_busy_2ticks", bus.busy, 1);
        cyc();
        tick = 1'b0;
        chk("fb_busy_3ticks", bus.busy, 0);
        cyc();
`ifdef LAYER_SEQ_QUEUE_EN
        chk("q_busy_replay", bus.busy, 1);
        cyc();
        chk("q_ss_replay", bus.shift_start, 1);
        chk("q_col_replay", bus.player_col, 3);
        chk("q_map_odd", (bus.layer_map & ~ODD) == 7'd0 && bus.layer_map != 7'd0, 1);
`else
        chk("nq_busy", bus.busy, 0);
        cyc();
        chk("nq_ss", bus.shift_start, 0);
        chk("nq_col", bus.player_col, 4);
`endif

        // Asynchronous reset during the shift pulse.
        reinit();
        bus.jump_right = 1'b1;
        cyc();
        bus.jump_right = 1'b0;
        cyc();
        chk("ar_ss_before", bus.shift_start, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", bus.busy, 0);
        chk("ar_ss", bus.shift_start, 0);
        chk("ar_map", bus.layer_map, 0);
        chk("ar_col", bus.player_col, 3);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ar_no_ss", bus.shift_start, 0);
        end
        model_init();

        // Walk to column 0, probe boundaries, then fall into a gap.
        reinit();
        w = 0;
        while (genl(lstep(m_lfsr), EVEN, ODD)[1] && w < 256) begin
            cyc();
            w++;
        end
        chk("wait_gap", w < 256, 1);
        move(1'b1);
        move(1'b1);
        move(1'b1);
        chk("walk_col0", bus.player_col, 0);
        bus.jump_left = 1'b1;
        cyc();
        bus.jump_left = 1'b0;
        chk("edge_busy", bus.busy, 0);
        chk("edge_col", bus.player_col, 0);
        bus.jump_left = 1'b1;
        bus.jump_right = 1'b1;
        cyc();
        bus.jump_left = 1'b0;
        bus.jump_right = 1'b0;
        chk("both_busy", bus.busy, 0);
        chk("both_over", bus.game_over, 0);
        chk("both_col", bus.player_col, 0);
        bus.jump_right = 1'b1;
        cyc();
        bus.jump_right = 1'b0;
        chk("gap_over", bus.game_over, 1);
        chk("gap_busy", bus.busy, 0);
        cyc();
        chk("gap_no_ss", bus.shift_start, 0);
        chk("gap_col", bus.player_col, 0);
        bus.jump_right = 1'b1;
        cyc();
        bus.jump_right = 1'b0;
        cyc();
        chk("over_ignore_col", bus.player_col, 0);
        chk("over_hold", bus.game_over, 1);
        game_en = 1'b0;
        cyc();
        chk("reinit_over", bus.game_over, 0);
        chk("reinit_col", bus.player_col, 3);
        chk("reinit_map", bus.layer_map, 0);
        game_en = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
